lot_occupancy: RTL
==================

Name: lot_occupancy

Overview:
- Consumes the one-cycle `enter`/`exit` event pulses from the parking-lot gate sensor FSM, directly downstream of it.
- Maintains a saturating car count bounded by lot capacity and tracks an EMPTY/PARTIAL/FULL occupancy state.
- Flags rejected events and drives six active-low 7-segment displays: count, "CLEAr" when empty, "FULL" when full.

Parameters:
- CAPACITY, 16, maximum number of cars; legal range 1..99.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enter  input  1  car-entered event from gate FSM (nominally one cycle)
- exit  input  1  car-exited event from gate FSM (nominally one cycle)
- count  output  7  current occupancy, 0..CAPACITY
- full  output  1  high while count == CAPACITY
- empty  output  1  high while count == 0
- reject  output  1  one-cycle pulse when an event is ignored
- HEX0..HEX5  output  7 each  7-segment patterns, active-low, bit order gfedcba

Behaviour:
- One clock; reset is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values: count=0, state=S_EMPTY, full=0, empty=1, reject=0. During reset, enter_d<=enter and exit_d<=exit.
- Reset mid-operation clears count on that edge regardless of any event present.
- Because enter_d/exit_d load the live inputs during reset, a level held high across reset release is not counted.
- Event detection: rising-edge detect with registered copies enter_d/exit_d.
  - ev_in = enter & ~enter_d; ev_out = exit & ~exit_d.
  - An input held high for N cycles counts once.
- Latency: count, state, full, empty and reject update on the same edge at which the event is first sampled. HEX outputs are combinational from registered count/state, so they add no extra latency.
- Count update (priority order):
  - ev_in & ev_out: count unchanged, reject=0. This holds even when full or empty.
  - ev_in only, count<CAPACITY: count+1.
  - ev_in only, count==CAPACITY: count unchanged, reject=1 for one cycle.
  - ev_out only, count>0: count-1.
  - ev_out only, count==0: count unchanged, reject=1 for one cycle.
  - No event: hold, reject=0.
- Arithmetic: 7-bit unsigned. The count never wraps; saturation is by rejection.
- State machine (explicit register, must stay consistent with count):
  - S_EMPTY: goes to S_PARTIAL on an accepted entry, or straight to S_FULL if CAPACITY==1. Otherwise stays.
  - S_PARTIAL: goes to S_FULL when the new count equals CAPACITY; goes to S_EMPTY when the new count equals 0; otherwise stays.
  - S_FULL: goes to S_PARTIAL on an accepted exit, or to S_EMPTY if CAPACITY==1.
  - full = (state==S_FULL); empty = (state==S_EMPTY); they are never both high.
- Display:
  - Digits: tens = count/10, ones = count%10.
  - S_EMPTY: HEX5..HEX1 = C,L,E,A,r; HEX0 = 0.
  - S_FULL: HEX5..HEX2 = F,U,L,L; HEX1 = tens; HEX0 = ones.
  - S_PARTIAL: HEX5..HEX2 blank; HEX1 = tens, blanked when tens==0; HEX0 = ones.
- Segment codes:
  - Digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Letters: C=1000110, L=1000111, E=0000110, A=0001000, r=0101111, F=0001110, U=1000001.
  - Blank=1111111.

Test Plan:
- Reset with enter=1 held, then release with enter still high → count=0, empty=1, HEX5..HEX0 = CLEAr0; no increment until enter drops and rises again.
- Three one-cycle enter pulses spaced 4 cycles apart → count=3 on the edge of the third pulse; S_PARTIAL; HEX1 blank, HEX0=0110000.
- enter held high 5 cycles → count increments by exactly 1.
- With CAPACITY=16, issue 17 enter pulses → count=16, full=1, HEX5..HEX0 = F,U,L,L,1,6. The 17th pulse gives reject=1 for one cycle and count stays 16.
- From empty, one exit pulse → reject=1 for one cycle, count=0, empty stays 1.
- At count=5, enter and exit rise on the same cycle → count=5, reject=0. Then assert reset while count=5 → count=0, S_EMPTY on the next edge.

Source files
------------

// File: rtl/lot_occupancy.sv
// Parking-lot occupancy tracker: edge-detected enter/exit events drive a
// saturating car count, an EMPTY/PARTIAL/FULL state and six 7-segment displays.
module lot_occupancy #(
   parameter int CAPACITY = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enter,
   input  logic       exit,
   output logic [6:0] count,
   output logic       full,
   output logic       empty,
   output logic       reject,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5
);

   typedef enum logic [1:0] {
      S_EMPTY,
      S_PARTIAL,
      S_FULL
   } state_t;

   localparam logic [6:0] CAP = 7'(CAPACITY);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_L     = 7'b1000111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_R     = 7'b0101111;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_U     = 7'b1000001;

   state_t     state;
   state_t     next_state;
   logic [6:0] next_count;
   logic       next_reject;
   logic       enter_d;
   logic       exit_d;
   logic       ev_in;
   logic       ev_out;
   logic       take_in;
   logic       take_out;
   logic [3:0] tens;
   logic [3:0] ones;

   function automatic logic [6:0] digit_seg(input logic [3:0] d);
      logic [6:0] seg;
      case (d)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   assign ev_in  = enter & ~enter_d;
   assign ev_out = exit & ~exit_d;

   // Simultaneous entry and exit cancel out and are never a rejection.
   always_comb begin
      next_count  = count;
      next_reject = 1'b0;
      take_in     = 1'b0;
      take_out    = 1'b0;
      if (ev_in && !ev_out) begin
         if (count < CAP) begin
            take_in    = 1'b1;
            next_count = count + 7'd1;
         end else begin
            next_reject = 1'b1;
         end
      end else if (ev_out && !ev_in) begin
         if (count > 7'd0) begin
            take_out   = 1'b1;
            next_count = count - 7'd1;
         end else begin
            next_reject = 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_EMPTY: begin
            if (take_in)
               next_state = (CAP == 7'd1) ? S_FULL : S_PARTIAL;
         end
         S_PARTIAL: begin
            if (next_count == CAP)
               next_state = S_FULL;
            else if (next_count == 7'd0)
               next_state = S_EMPTY;
         end
         S_FULL: begin
            if (take_out)
               next_state = (CAP == 7'd1) ? S_EMPTY : S_PARTIAL;
         end
         default: next_state = S_EMPTY;
      endcase
   end

   // The delayed copies load even during reset so a level held across
   // reset release does not look like a fresh event.
   always_ff @(posedge clk) begin
      enter_d <= enter;
      exit_d  <= exit;
      if (reset) begin
         count  <= 7'd0;
         state  <= S_EMPTY;
         reject <= 1'b0;
      end else begin
         count  <= next_count;
         state  <= next_state;
         reject <= next_reject;
      end
   end

   assign full  = (state == S_FULL);
   assign empty = (state == S_EMPTY);

   assign tens = 4'(count / 7'd10);
   assign ones = 4'(count % 7'd10);

   always_comb begin
      HEX5 = SEG_BLANK;
      HEX4 = SEG_BLANK;
      HEX3 = SEG_BLANK;
      HEX2 = SEG_BLANK;
      HEX1 = SEG_BLANK;
      HEX0 = digit_seg(ones);
      case (state)
         S_EMPTY: begin
            HEX5 = SEG_C;
            HEX4 = SEG_L;
            HEX3 = SEG_E;
            HEX2 = SEG_A;
            HEX1 = SEG_R;
            HEX0 = digit_seg(4'd0);
         end
         S_FULL: begin
            HEX5 = SEG_F;
            HEX4 = SEG_U;
            HEX3 = SEG_L;
            HEX2 = SEG_L;
            HEX1 = digit_seg(tens);
         end
         S_PARTIAL: begin
            if (tens != 4'd0)
               HEX1 = digit_seg(tens);
         end
         default: begin
            HEX0 = SEG_BLANK;
         end
      endcase
   end

endmodule
